// File: rtl/dcache_port_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter
//
// Purpose:
//   Shares the single data-cache port between the ROB store-commit path and
//   the load/store-buffer load path. One request is latched at a time and
//   drives the cache until mem_resp. The response is routed back to the
//   requester that owns the access.
//   Stores normally win. A starvation counter limits how many store grants in
//   a row can lock out a waiting load. A load that is in flight when a flush
//   arrives is completed on the cache side, but its response is discarded.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              pipeline flush (kills waiting/in-flight loads)
//   st_req/st_addr/st_wdata/st_byte_en -> st_resp       store requester
//   ld_req/ld_addr/ld_tag -> ld_resp/ld_rdata/ld_resp_tag  load requester
//   mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable -> cache
//   mem_rdata/mem_resp <- cache
// -----------------------------------------------------------------------------
module dcache_port_arbiter #(
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             st_req,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_wdata,
  input  logic [3:0]       st_byte_en,
  output logic             st_resp,
  input  logic             ld_req,
  input  logic [31:0]      ld_addr,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_resp,
  output logic [31:0]      ld_rdata,
  output logic [TAG_W-1:0] ld_resp_tag,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_byte_enable,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_resp
);

  localparam int             CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ST_BUSY,
    LD_BUSY,
    LD_ABORT   // flushed load still waiting for its mem_resp
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic ld_waiting;
  logic starved;
  logic grant_st;
  logic grant_ld;

  // A flushed load is never treated as waiting, so it cannot be granted and
  // cannot add to the starvation count.
  assign ld_waiting = ld_req & ~flush;
  assign starved    = ld_waiting & (starve_q == LIMIT);
  assign grant_st   = (state_q == IDLE) & st_req & ~starved;
  assign grant_ld   = (state_q == IDLE) & ~grant_st & ld_waiting;

  // Next-state, request latch and starvation counter update.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    tag_d    = tag_q;
    starve_d = starve_q;

    unique case (state_q)
      IDLE: begin
        if (grant_st) begin
          state_d = ST_BUSY;
          addr_d  = st_addr;
          wdata_d = st_wdata;
          be_d    = st_byte_en;
        end else if (grant_ld) begin
          state_d = LD_BUSY;
          addr_d  = ld_addr;
          wdata_d = '0;
          be_d    = 4'hF;
          tag_d   = ld_tag;
        end
      end
      ST_BUSY:  if (mem_resp) state_d = IDLE;
      LD_BUSY: begin
        if (mem_resp)   state_d = IDLE;
        else if (flush) state_d = LD_ABORT;
      end
      LD_ABORT: if (mem_resp) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Count consecutive store grants that bypass a waiting load; saturate so
    // the load keeps winning until it is actually granted.
    if (flush || grant_ld) begin
      starve_d = '0;
    end else if (grant_st) begin
      if (!ld_waiting)          starve_d = '0;
      else if (starve_q != LIMIT) starve_d = starve_q + CNT_W'(1);
    end
  end

  // Cache and response outputs. Everything is forced low while rst is high so
  // an access in progress is abandoned in the reset cycle itself.
  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    st_resp         = 1'b0;
    ld_resp         = 1'b0;
    ld_rdata        = '0;
    ld_resp_tag     = '0;

    if (!rst) begin
      unique case (state_q)
        ST_BUSY: begin
          mem_write       = 1'b1;
          mem_address     = addr_q;
          mem_wdata       = wdata_q;
          mem_byte_enable = be_q;
          st_resp         = mem_resp;
        end
        LD_BUSY: begin
          mem_read        = 1'b1;
          mem_address     = addr_q;
          mem_byte_enable = 4'hF;
          // A flush arriving together with the data still kills the response.
          if (mem_resp && !flush) begin
            ld_resp     = 1'b1;
            ld_rdata    = mem_rdata;
            ld_resp_tag = tag_q;
          end
        end
        LD_ABORT: begin
          // The strobe has to stay up until the cache answers.
          mem_read        = 1'b1;
          mem_address     = addr_q;
          mem_byte_enable = 4'hF;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      tag_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      tag_q    <= tag_d;
      starve_q <= starve_d;
    end
  end

endmodule
